// File: rtl/adc_frame_pkg.sv
// Shared types and constants for the dual-ADC frame packer.
// FRAME_CHECKSUM_EN adds a trailing checksum byte to every frame.
package adc_frame_pkg;

  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

`ifdef FRAME_CHECKSUM_EN
  localparam int FRAME_LEN = 6;
`else
  localparam int FRAME_LEN = 5;
`endif

  // ch0 sits in the upper half so the packed pair reads {ch0, ch1}
  typedef struct packed {
    logic [11:0] ch0;
    logic [11:0] ch1;
  } pair_t;

  typedef enum logic [2:0] {IDLE, SYNC, STAT, B0, B1, B2, CSUM} state_t;

  // Checksum covers STAT and the three payload bytes, not SYNC
  function automatic logic [7:0] frame_csum(input logic [1:0] flags, input pair_t p);
    logic [7:0] s;
    s = {6'b0, flags};
    s = s + p.ch0[11:4];
    s = s + {p.ch0[3:0], p.ch1[11:8]};
    s = s + p.ch1[7:0];
    return s;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO, power-of-two depth, combinational read of the head entry.
// A push while full is accepted only when a pop happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count;
  logic             do_push, do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];
  assign level   = count;

  // Storage array, no reset needed on data
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // Pointers wrap naturally because depth is a power of two
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/adc_frame_packer.sv
// Pairs ch0/ch1 samples, queues pairs, and serialises each into a byte frame
// SYNC, STAT, B0, B1, B2 on a valid/ready stream. Overwrite and drop events
// are reported in STAT. Define FRAME_CHECKSUM_EN to append a CSUM byte.
module adc_frame_packer
  import adc_frame_pkg::*;
#(
  parameter int         FIFO_DEPTH = 8,
  parameter logic [7:0] SYNC_BYTE  = SYNC_BYTE_DEF
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [11:0]                   ch0_data_i,
  input  logic                          ch0_strb_i,
  input  logic [11:0]                   ch1_data_i,
  input  logic                          ch1_strb_i,
  output logic [7:0]                    byte_o,
  output logic                          valid_o,
  input  logic                          ready_i,
  output logic [$clog2(FIFO_DEPTH):0]   level_o
);

  logic [11:0] slot0, slot1;
  logic [1:0]  have;
  logic        ovr, drop;
  logic        push, ovr_evt, drop_evt;
  logic        fifo_full, fifo_empty, fifo_push, pop;
  logic        fire, frame_end;
  pair_t       wr_pair, rd_pair, cur;
  logic [1:0]  stat;
  state_t      state;

  assign push      = have[0] && have[1];
  assign fifo_push = push && !fifo_full;
  assign drop_evt  = push && fifo_full;
  // A strobe in the push cycle lands in a slot being freed, so it is not an overwrite
  assign ovr_evt   = !push && ((ch0_strb_i && have[0]) || (ch1_strb_i && have[1]));
  assign wr_pair   = '{ch0: slot0, ch1: slot1};

  sync_fifo #(
    .WIDTH ($bits(pair_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (fifo_push),
    .wdata (wr_pair),
    .pop   (pop),
    .rdata (rd_pair),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (level_o)
  );

  // Sample slots: latch on strobe, release both once the pair is pushed
  always_ff @(posedge clock) begin
    if (reset) begin
      slot0 <= '0;
      slot1 <= '0;
      have  <= '0;
    end else begin
      if (ch0_strb_i) begin
        slot0   <= ch0_data_i;
        have[0] <= 1'b1;
      end else if (push) begin
        have[0] <= 1'b0;
      end
      if (ch1_strb_i) begin
        slot1   <= ch1_data_i;
        have[1] <= 1'b1;
      end else if (push) begin
        have[1] <= 1'b0;
      end
    end
  end

  // Sticky loss flags; cleared when captured by a pop unless re-set that cycle
  always_ff @(posedge clock) begin
    if (reset) begin
      ovr  <= 1'b0;
      drop <= 1'b0;
    end else begin
      ovr  <= ovr_evt  || (ovr  && !pop);
      drop <= drop_evt || (drop && !pop);
    end
  end

  assign fire = valid_o && ready_i;
`ifdef FRAME_CHECKSUM_EN
  assign frame_end = (state == CSUM) && fire;
`else
  assign frame_end = (state == B2) && fire;
`endif

  // Pop only when starting a frame: from IDLE or straight off the last byte
  always_comb begin
    pop = 1'b0;
    if (!fifo_empty && (state == IDLE || frame_end)) pop = 1'b1;
  end

  // Frame sequencer with registered byte/valid outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= IDLE;
      byte_o  <= '0;
      valid_o <= 1'b0;
      cur     <= '0;
      stat    <= '0;
    end else if (pop) begin
      cur     <= rd_pair;
      stat    <= {ovr, drop};
      state   <= SYNC;
      byte_o  <= SYNC_BYTE;
      valid_o <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          valid_o <= 1'b0;
        end
        SYNC: if (fire) begin
          state  <= STAT;
          byte_o <= {6'b0, stat};
        end
        STAT: if (fire) begin
          state  <= B0;
          byte_o <= cur.ch0[11:4];
        end
        B0: if (fire) begin
          state  <= B1;
          byte_o <= {cur.ch0[3:0], cur.ch1[11:8]};
        end
        B1: if (fire) begin
          state  <= B2;
          byte_o <= cur.ch1[7:0];
        end
`ifdef FRAME_CHECKSUM_EN
        B2: if (fire) begin
          state  <= CSUM;
          byte_o <= frame_csum(stat, cur);
        end
        CSUM: if (fire) begin
          state   <= IDLE;
          byte_o  <= '0;
          valid_o <= 1'b0;
        end
`else
        B2: if (fire) begin
          state   <= IDLE;
          byte_o  <= '0;
          valid_o <= 1'b0;
        end
`endif
        default: begin
          state   <= IDLE;
          byte_o  <= '0;
          valid_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_adc_frame_packer.sv
// Directed bench for adc_frame_packer: expected byte stream kept in a queue,
// checked byte by byte as the sink accepts them; latency, level, stall and
// reset behaviour checked at fixed points. Honours FRAME_CHECKSUM_EN.
module tb_adc_frame_packer;

  logic        clock = 1'b0;
  logic        reset;
  logic [11:0] ch0_data_i, ch1_data_i;
  logic        ch0_strb_i, ch1_strb_i;
  logic [7:0]  byte_o;
  logic        valid_o;
  logic        ready_i;
  logic [3:0]  level_o;

  int          checks = 0;
  int          errors = 0;
  logic [7:0]  exp_q [$];
  logic        hold_pending = 1'b0;
  logic [7:0]  held_byte = '0;

  adc_frame_packer #(.FIFO_DEPTH(8), .SYNC_BYTE(8'hA5)) dut (
    .clock      (clock),
    .reset      (reset),
    .ch0_data_i (ch0_data_i),
    .ch0_strb_i (ch0_strb_i),
    .ch1_data_i (ch1_data_i),
    .ch1_strb_i (ch1_strb_i),
    .byte_o     (byte_o),
    .valid_o    (valid_o),
    .ready_i    (ready_i),
    .level_o    (level_o)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push_frame(input logic [7:0] stat, input logic [11:0] c0, input logic [11:0] c1);
    logic [7:0] b0, b1, b2;
    b0 = c0[11:4];
    b1 = {c0[3:0], c1[11:8]};
    b2 = c1[7:0];
    exp_q.push_back(8'hA5);
    exp_q.push_back(stat);
    exp_q.push_back(b0);
    exp_q.push_back(b1);
    exp_q.push_back(b2);
`ifdef FRAME_CHECKSUM_EN
    exp_q.push_back(8'(stat + b0 + b1 + b2));
`endif
  endtask

  task automatic offer_pair(input logic [11:0] c0, input logic [11:0] c1);
    ch0_data_i = c0; ch1_data_i = c1;
    ch0_strb_i = 1'b1; ch1_strb_i = 1'b1;
    tick();
    ch0_strb_i = 1'b0; ch1_strb_i = 1'b0;
  endtask

  task automatic strobe0(input logic [11:0] c0);
    ch0_data_i = c0; ch0_strb_i = 1'b1;
    tick();
    ch0_strb_i = 1'b0;
  endtask

  task automatic strobe1(input logic [11:0] c1);
    ch1_data_i = c1; ch1_strb_i = 1'b1;
    tick();
    ch1_strb_i = 1'b0;
  endtask

  task automatic wait_drain(input string tag, input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || valid_o) && n < budget) begin
      tick();
      n++;
    end
    chk(tag, exp_q.size(), 0);
  endtask

  // Sink side: every accepted byte must be the next expected one, and a
  // stalled byte must not change or drop valid
  always @(negedge clock) begin
    if (!reset && hold_pending) begin
      chk("stall_valid", valid_o, 1);
      chk("stall_byte", byte_o, held_byte);
    end
    if (!reset && valid_o && ready_i) begin
      chk("stream_avail", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) chk("stream_byte", byte_o, exp_q.pop_front());
    end
    hold_pending = !reset && valid_o && !ready_i;
    held_byte    = byte_o;
  end

  initial begin
    reset = 1'b1; ready_i = 1'b1;
    ch0_data_i = '0; ch1_data_i = '0; ch0_strb_i = 1'b0; ch1_strb_i = 1'b0;
    tick(); tick(); tick();
    chk("rst_valid", valid_o, 0);
    chk("rst_byte", byte_o, 0);
    chk("rst_level", level_o, 0);
    reset = 1'b0;
    tick();

    // 1: split strobes; A5 00 AB C1 23 [8F]; valid two edges after ch1 strobe
    push_frame(8'h00, 12'hABC, 12'h123);
    strobe0(12'hABC);
    tick(); tick(); tick();
    strobe1(12'h123);
    chk("t1_valid_e0", valid_o, 0);
    chk("t1_level_e0", level_o, 0);
    tick();
    chk("t1_valid_e1", valid_o, 0);
    chk("t1_level_e1", level_o, 1);
    tick();
    chk("t1_valid_e2", valid_o, 1);
    chk("t1_sync_e2", byte_o, 8'hA5);
    chk("t1_level_e2", level_o, 0);
    wait_drain("t1_drain", 40);

    // 2: same-cycle strobes; A5 00 00 0F FF [0E]; level peaks at 1
    push_frame(8'h00, 12'h000, 12'hFFF);
    offer_pair(12'h000, 12'hFFF);
    chk("t2_level_e0", level_o, 0);
    tick();
    chk("t2_level_e1", level_o, 1);
    tick();
    chk("t2_level_e2", level_o, 0);
    chk("t2_valid_e2", valid_o, 1);
    wait_drain("t2_drain", 40);

    // 3: ch0 overwritten; A5 02 22 23 33 [7A], then next frame STAT=00
    push_frame(8'h02, 12'h222, 12'h333);
    strobe0(12'h111);
    tick();
    strobe0(12'h222);
    tick();
    strobe1(12'h333);
    wait_drain("t3_drain", 40);
    push_frame(8'h00, 12'h444, 12'h555);
    offer_pair(12'h444, 12'h555);
    wait_drain("t3_next_drain", 40);

    // 4: sink stalled. Pair 0 is popped into the sequencer at once, pairs
    // 1..8 fill the FIFO, pair 9 is dropped; pair 1 is the first pop after
    // the drop and carries STAT=01
    ready_i = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (i < 9) push_frame((i == 1) ? 8'h01 : 8'h00, 12'h100 + 12'(i), 12'h200 + 12'(i));
      offer_pair(12'h100 + 12'(i), 12'h200 + 12'(i));
      tick();
    end
    tick(); tick();
    chk("t4_level_full", level_o, 8);
    chk("t4_valid_stall", valid_o, 1);
    chk("t4_byte_stall", byte_o, 8'hA5);
    ready_i = 1'b1;
    wait_drain("t4_drain", 200);
    chk("t4_level_end", level_o, 0);

    // 5: reset after B0 accepted, with one more pair waiting in the FIFO
    ready_i = 1'b0;
    push_frame(8'h00, 12'h5A5, 12'h3C3);
    offer_pair(12'h5A5, 12'h3C3);
    tick();
    offer_pair(12'h0F0, 12'h00F);
    tick(); tick();
    chk("t5_valid_pre", valid_o, 1);
    chk("t5_level_pre", level_o, 1);
    ready_i = 1'b1;
    tick(); tick(); tick();
    ready_i = 1'b0;
    reset = 1'b1;
    exp_q.delete();
    tick();
    chk("t5_valid_rst", valid_o, 0);
    chk("t5_level_rst", level_o, 0);
    reset = 1'b0;
    ready_i = 1'b1;
    tick(); tick();
    chk("t5_idle_after", valid_o, 0);
    push_frame(8'h00, 12'h456, 12'h789);
    offer_pair(12'h456, 12'h789);
    wait_drain("t5_drain", 40);

    // 6: random sink back-pressure over 100 random pairs
    for (int p = 0; p < 100; p++) begin
      logic [11:0] a, b;
      a = 12'($urandom);
      b = 12'($urandom);
      push_frame(8'h00, a, b);
      for (int k = 0; k < 16; k++) begin
        ready_i = ($urandom_range(0, 3) != 0);
        if (k == 0) begin ch0_data_i = a; ch0_strb_i = 1'b1; end
        if (k == 3) begin ch1_data_i = b; ch1_strb_i = 1'b1; end
        tick();
        ch0_strb_i = 1'b0; ch1_strb_i = 1'b0;
      end
    end
    ready_i = 1'b1;
    wait_drain("t6_drain", 400);
    chk("t6_level_end", level_o, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
